if_id_skid_reg: RTL and testbench

//   Parametrised IF->ID pipeline register with valid/ready handshake and a 2-entry

---
 rtl/if_id_skid_reg_pkg.sv | 31 +++
 rtl/if_id_skid_reg_if.sv | 37 +++
 rtl/if_id_skid_reg_slot.sv | 41 ++++
 rtl/if_id_skid_reg.sv | 161 ++++++++++++++++
 tb/tb_if_id_skid_reg.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/if_id_skid_reg_pkg.sv
// Shared types and constants for the IF->ID stage register.
package if_id_skid_reg_pkg;

    // Instruction shown to decode when no entry is valid
    localparam logic [31:0] NOP_INSTR = 32'h00000000;

    // Fetch exception codes; 0 means no exception
    localparam logic [4:0] EXC_NONE = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    // One buffered fetch entry at the default widths
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] pc8;
        logic [4:0]  exc;
        logic        bd;
    } entry_t;

    // Occupancy encoded as {main_valid, skid_valid}; 2'b01 cannot occur
    typedef enum logic [1:0] {
        StEmpty = 2'b00,
        StOne   = 2'b10,
        StFull  = 2'b11
    } occ_e;

endpackage

// File: rtl/if_id_skid_reg_if.sv
// Fetch/decode handshake bundle for the IF->ID stage register.
interface if_id_skid_reg_if #(
    parameter int unsigned INSTR_W = 32,
    parameter int unsigned PC_W    = 32,
    parameter int unsigned EXC_W   = 5
);
    logic               in_valid;
    logic               in_ready;
    logic [INSTR_W-1:0] in_instr;
    logic [PC_W-1:0]    in_pc;
    logic [EXC_W-1:0]   in_exc;
    logic               in_bd;
    logic               flush;
    logic               out_valid;
    logic               out_ready;
    logic [INSTR_W-1:0] out_instr;
    logic [PC_W-1:0]    out_pc;
    logic [PC_W-1:0]    out_pc4;
    logic [PC_W-1:0]    out_pc8;
    logic [EXC_W-1:0]   out_exc;
    logic               out_has_exc;
    logic               out_bd;

    // The stage register's view
    modport slave (
        input  in_valid, in_instr, in_pc, in_exc, in_bd, flush, out_ready,
        output in_ready, out_valid, out_instr, out_pc, out_pc4, out_pc8,
               out_exc, out_has_exc, out_bd
    );

    // The surrounding pipeline's view
    modport master (
        output in_valid, in_instr, in_pc, in_exc, in_bd, flush, out_ready,
        input  in_ready, out_valid, out_instr, out_pc, out_pc4, out_pc8,
               out_exc, out_has_exc, out_bd
    );
endinterface

// File: rtl/if_id_skid_reg_slot.sv
// Single fetch entry register; derives PC+4/PC+8 at load time.
module if_id_skid_reg_slot #(
    parameter int unsigned INSTR_W = 32,
    parameter int unsigned PC_W    = 32,
    parameter int unsigned EXC_W   = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic [INSTR_W-1:0] d_instr,
    input  logic [PC_W-1:0]    d_pc,
    input  logic [EXC_W-1:0]   d_exc,
    input  logic               d_bd,
    output logic [INSTR_W-1:0] q_instr,
    output logic [PC_W-1:0]    q_pc,
    output logic [PC_W-1:0]    q_pc4,
    output logic [PC_W-1:0]    q_pc8,
    output logic [EXC_W-1:0]   q_exc,
    output logic               q_bd
);

    // Capture the payload on load; PC sums wrap at PC_W bits
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q_instr <= '0;
            q_pc    <= '0;
            q_pc4   <= '0;
            q_pc8   <= '0;
            q_exc   <= '0;
            q_bd    <= 1'b0;
        end else if (load) begin
            q_instr <= d_instr;
            q_pc    <= d_pc;
            q_pc4   <= d_pc + PC_W'(4);
            q_pc8   <= d_pc + PC_W'(8);
            q_exc   <= d_exc;
            q_bd    <= d_bd;
        end
    end

endmodule

// File: rtl/if_id_skid_reg.sv
// IF->ID pipeline register with a two-entry skid buffer, flush and stall counter.
module if_id_skid_reg #(
    parameter int unsigned        INSTR_W   = 32,
    parameter int unsigned        PC_W      = 32,
    parameter int unsigned        EXC_W     = 5,
    parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(if_id_skid_reg_pkg::NOP_INSTR),
    parameter int unsigned        CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    if_id_skid_reg_if.slave  bus,
    output logic [CNT_W-1:0] stall_cnt
);
    import if_id_skid_reg_pkg::*;

    logic main_valid_q, main_valid_d;
    logic skid_valid_q, skid_valid_d;
    logic main_load, main_from_skid, skid_load;
    logic in_fire, out_fire;
    occ_e occ;

    logic [INSTR_W-1:0] main_instr, skid_instr, main_d_instr;
    logic [PC_W-1:0]    main_pc, main_pc4, main_pc8, main_d_pc;
    logic [PC_W-1:0]    skid_pc, skid_pc4, skid_pc8;
    logic [EXC_W-1:0]   main_exc, skid_exc, main_d_exc;
    logic               main_bd, skid_bd, main_d_bd;
    logic [CNT_W-1:0]   stall_q;

    // Main is refilled from skid, so skid's own PC sums are never read
    logic unused_skid_pc;
    assign unused_skid_pc = ^{skid_pc4, skid_pc8};

    assign in_fire  = bus.in_valid && !skid_valid_q;
    assign out_fire = main_valid_q && bus.out_ready;
    assign occ      = occ_e'({main_valid_q, skid_valid_q});

    // Occupancy transitions; flush overrides everything
    always_comb begin
        main_valid_d   = main_valid_q;
        skid_valid_d   = skid_valid_q;
        main_load      = 1'b0;
        main_from_skid = 1'b0;
        skid_load      = 1'b0;
        unique case (occ)
            StEmpty: begin
                if (in_fire) begin
                    main_valid_d = 1'b1;
                    main_load    = 1'b1;
                end
            end
            StOne: begin
                if (out_fire) begin
                    if (in_fire) main_load = 1'b1;
                    else         main_valid_d = 1'b0;
                end else if (in_fire) begin
                    skid_load    = 1'b1;
                    skid_valid_d = 1'b1;
                end
            end
            StFull: begin
                if (out_fire) begin
                    main_load      = 1'b1;
                    main_from_skid = 1'b1;
                    skid_valid_d   = 1'b0;
                end
            end
            default: begin
                main_valid_d = 1'b0;
                skid_valid_d = 1'b0;
            end
        endcase
        if (bus.flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end
    end

    // Main slot takes the older skid entry ahead of new input to keep FIFO order
    always_comb begin
        main_d_instr = bus.in_instr;
        main_d_pc    = bus.in_pc;
        main_d_exc   = bus.in_exc;
        main_d_bd    = bus.in_bd;
        if (main_from_skid) begin
            main_d_instr = skid_instr;
            main_d_pc    = skid_pc;
            main_d_exc   = skid_exc;
            main_d_bd    = skid_bd;
        end
    end

    // Valid flags and saturating stall counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            stall_q      <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            if (main_valid_q && !bus.out_ready && (stall_q != '1)) begin
                stall_q <= stall_q + CNT_W'(1);
            end
        end
    end

    if_id_skid_reg_slot #(
        .INSTR_W(INSTR_W),
        .PC_W   (PC_W),
        .EXC_W  (EXC_W)
    ) u_main (
        .clk    (clk),
        .reset  (reset),
        .load   (main_load),
        .d_instr(main_d_instr),
        .d_pc   (main_d_pc),
        .d_exc  (main_d_exc),
        .d_bd   (main_d_bd),
        .q_instr(main_instr),
        .q_pc   (main_pc),
        .q_pc4  (main_pc4),
        .q_pc8  (main_pc8),
        .q_exc  (main_exc),
        .q_bd   (main_bd)
    );

    if_id_skid_reg_slot #(
        .INSTR_W(INSTR_W),
        .PC_W   (PC_W),
        .EXC_W  (EXC_W)
    ) u_skid (
        .clk    (clk),
        .reset  (reset),
        .load   (skid_load),
        .d_instr(bus.in_instr),
        .d_pc   (bus.in_pc),
        .d_exc  (bus.in_exc),
        .d_bd   (bus.in_bd),
        .q_instr(skid_instr),
        .q_pc   (skid_pc),
        .q_pc4  (skid_pc4),
        .q_pc8  (skid_pc8),
        .q_exc  (skid_exc),
        .q_bd   (skid_bd)
    );

    assign bus.in_ready    = !skid_valid_q;
    assign bus.out_valid   = main_valid_q;
    assign bus.out_instr   = main_valid_q ? main_instr : NOP_INSTR;
    assign bus.out_pc      = main_pc;
    assign bus.out_pc4     = main_pc4;
    assign bus.out_pc8     = main_pc8;
    assign bus.out_exc     = main_valid_q ? main_exc : '0;
    assign bus.out_has_exc = main_valid_q && (main_exc != '0);
    assign bus.out_bd      = main_valid_q && main_bd;
    assign stall_cnt       = stall_q;

    illegal_occ_a: assert property (@(posedge clk) disable iff (!reset)
        !(skid_valid_q && !main_valid_q));

endmodule

// File: tb/tb_if_id_skid_reg.sv
// Bench for if_id_skid_reg: directed table, corner sequences, random vs queue model.
module tb_if_id_skid_reg;
    import if_id_skid_reg_pkg::*;

    localparam int unsigned CNT_W   = 4;
    localparam int          CNT_MAX = 15;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic [CNT_W-1:0] stall_cnt;

    if_id_skid_reg_if bus ();

    if_id_skid_reg #(
        .CNT_W(CNT_W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    int     nvec = 0;
    int     nerr = 0;
    entry_t mq[$];
    int     mcnt = 0;

    typedef struct {
        logic        iv;
        logic        ordy;
        logic        fl;
        logic [31:0] instr;
        logic [31:0] pc;
        logic        ev;
        logic        er;
        logic [31:0] ei;
        logic [31:0] epc;
        int          es;
    } vec_t;

    vec_t tbl[13];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic entry_t mk(input logic [31:0] instr, input logic [31:0] pc,
                                  input logic [4:0] exc, input logic bd);
        entry_t e;
        e.instr = instr;
        e.pc    = pc;
        e.pc4   = pc + 32'd4;
        e.pc8   = pc + 32'd8;
        e.exc   = exc;
        e.bd    = bd;
        return e;
    endfunction

    function automatic vec_t mkv(input logic iv, input logic ordy, input logic fl,
                                 input logic [31:0] instr, input logic [31:0] pc,
                                 input logic ev, input logic er, input logic [31:0] ei,
                                 input logic [31:0] epc, input int es);
        vec_t v;
        v.iv = iv; v.ordy = ordy; v.fl = fl; v.instr = instr; v.pc = pc;
        v.ev = ev; v.er = er; v.ei = ei; v.epc = epc; v.es = es;
        return v;
    endfunction

    task automatic drive(input logic iv, input logic ordy, input logic fl,
                         input logic [31:0] instr, input logic [31:0] pc,
                         input logic [4:0] exc, input logic bd);
        bus.in_valid  = iv;
        bus.out_ready = ordy;
        bus.flush     = fl;
        bus.in_instr  = instr;
        bus.in_pc     = pc;
        bus.in_exc    = exc;
        bus.in_bd     = bd;
    endtask

    // Advance the queue model on the current inputs, then clock the DUT
    task automatic tick();
        bit have  = mq.size() > 0;
        bit ofire = have && bus.out_ready;
        bit ifire = bus.in_valid && (mq.size() < 2);
        if (have && !bus.out_ready && mcnt < CNT_MAX) mcnt++;
        if (bus.flush) begin
            mq.delete();
        end else begin
            if (ofire) void'(mq.pop_front());
            if (ifire) mq.push_back(mk(bus.in_instr, bus.in_pc, bus.in_exc, bus.in_bd));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_model();
        bit     v = mq.size() > 0;
        entry_t f = '0;
        if (v) f = mq[0];
        chk("out_valid", bus.out_valid, v);
        chk("in_ready", bus.in_ready, mq.size() < 2);
        chk("out_instr", bus.out_instr, v ? f.instr : NOP_INSTR);
        chk("out_exc", bus.out_exc, v ? f.exc : EXC_NONE);
        chk("out_has_exc", bus.out_has_exc, v && (f.exc != 0));
        chk("out_bd", bus.out_bd, v && f.bd);
        chk("stall_cnt", stall_cnt, mcnt);
        if (v) begin
            chk("out_pc", bus.out_pc, f.pc);
            chk("out_pc4", bus.out_pc4, f.pc4);
            chk("out_pc8", bus.out_pc8, f.pc8);
        end
    endtask

    task automatic do_reset();
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0);
        reset = 1'b0;
        mq.delete();
        mcnt = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0);

        // Backpressure and flush, expectations written out per cycle
        tbl[0]  = mkv(1, 0, 0, 32'hA0000001, 32'h00400000, 1, 1, 32'hA0000001, 32'h00400000, 0);
        tbl[1]  = mkv(1, 0, 0, 32'hA0000002, 32'h00400004, 1, 0, 32'hA0000001, 32'h00400000, 1);
        tbl[2]  = mkv(1, 0, 0, 32'hA0000003, 32'h00400008, 1, 0, 32'hA0000001, 32'h00400000, 2);
        tbl[3]  = mkv(1, 0, 0, 32'hA0000003, 32'h00400008, 1, 0, 32'hA0000001, 32'h00400000, 3);
        tbl[4]  = mkv(1, 1, 0, 32'hA0000003, 32'h00400008, 1, 1, 32'hA0000002, 32'h00400004, 3);
        tbl[5]  = mkv(1, 1, 0, 32'hA0000003, 32'h00400008, 1, 1, 32'hA0000003, 32'h00400008, 3);
        tbl[6]  = mkv(0, 1, 0, 32'h0,        32'h0,        0, 1, 32'h0,        32'h0,        3);
        tbl[7]  = mkv(1, 0, 0, 32'hA0000004, 32'h0040000C, 1, 1, 32'hA0000004, 32'h0040000C, 3);
        tbl[8]  = mkv(1, 0, 0, 32'hA0000005, 32'h00400010, 1, 0, 32'hA0000004, 32'h0040000C, 4);
        tbl[9]  = mkv(1, 0, 1, 32'hA0000006, 32'h00400014, 0, 1, 32'h0,        32'h0,        5);
        tbl[10] = mkv(0, 1, 0, 32'h0,        32'h0,        0, 1, 32'h0,        32'h0,        5);
        tbl[11] = mkv(1, 1, 0, 32'hA0000007, 32'h00400018, 1, 1, 32'hA0000007, 32'h00400018, 5);
        tbl[12] = mkv(0, 1, 0, 32'h0,        32'h0,        0, 1, 32'h0,        32'h0,        5);

        do_reset();
        chk("reset out_valid", bus.out_valid, 1'b0);
        chk("reset in_ready", bus.in_ready, 1'b1);
        chk("reset out_instr", bus.out_instr, NOP_INSTR);
        chk("reset out_exc", bus.out_exc, EXC_NONE);
        chk("reset out_bd", bus.out_bd, 1'b0);
        chk("reset out_pc", bus.out_pc, 32'h0);
        chk("reset stall_cnt", stall_cnt, 0);

        for (int i = 0; i < 13; i++) begin
            drive(tbl[i].iv, tbl[i].ordy, tbl[i].fl, tbl[i].instr, tbl[i].pc, 5'd0, 1'b0);
            tick();
            chk($sformatf("tbl[%0d] out_valid", i), bus.out_valid, tbl[i].ev);
            chk($sformatf("tbl[%0d] in_ready", i), bus.in_ready, tbl[i].er);
            chk($sformatf("tbl[%0d] out_instr", i), bus.out_instr, tbl[i].ei);
            chk($sformatf("tbl[%0d] stall_cnt", i), stall_cnt, tbl[i].es);
            if (tbl[i].ev) chk($sformatf("tbl[%0d] out_pc", i), bus.out_pc, tbl[i].epc);
        end

        // Streaming at full throughput
        do_reset();
        for (int i = 0; i < 8; i++) begin
            drive(1, 1, 0, 32'h1000 + i, 32'h00400000 + 4 * i, 5'd0, 1'b0);
            tick();
            chk("stream out_valid", bus.out_valid, 1'b1);
            chk("stream out_instr", bus.out_instr, 32'h1000 + i);
            chk("stream out_pc8", bus.out_pc8, 32'h00400008 + 4 * i);
        end

        // Exception/delay-slot tags and PC wrap
        do_reset();
        drive(1, 1, 0, 32'hDEADBEEF, 32'hFFFFFFFC, EXC_ADEL, 1'b1);
        tick();
        chk("tag out_has_exc", bus.out_has_exc, 1'b1);
        chk("tag out_exc", bus.out_exc, EXC_ADEL);
        chk("tag out_bd", bus.out_bd, 1'b1);
        chk("tag out_pc4", bus.out_pc4, 32'h0);
        chk("tag out_pc8", bus.out_pc8, 32'h4);

        // Asynchronous reset while FULL
        do_reset();
        drive(1, 0, 0, 32'h11, 32'h100, 5'd0, 1'b0);
        tick();
        drive(1, 0, 0, 32'h22, 32'h104, 5'd0, 1'b0);
        tick();
        chk("prefill in_ready", bus.in_ready, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        chk("async out_valid", bus.out_valid, 1'b0);
        chk("async in_ready", bus.in_ready, 1'b1);
        chk("async out_instr", bus.out_instr, 32'h0);
        chk("async stall_cnt", stall_cnt, 0);

        // Stall counter saturation
        do_reset();
        drive(1, 0, 0, 32'h33, 32'h200, 5'd0, 1'b0);
        tick();
        drive(0, 0, 0, 32'h0, 32'h0, 5'd0, 1'b0);
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (k == 10 || k == 15 || k == 20) chk("sat stall_cnt", stall_cnt, (k < 15) ? k : 15);
        end

        // Random traffic against the queue model
        do_reset();
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 9) < 6,
                  $urandom_range(0, 15) == 0, $urandom, $urandom,
                  ($urandom_range(0, 3) == 0) ? 5'($urandom_range(1, 31)) : 5'd0,
                  1'($urandom_range(0, 1)));
            tick();
            check_model();
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
